// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - shares the single-port command RAM between the SPI slave and a local host
//
// Purpose: locks the RAM to one requester for a whole address/data(/read-return) transaction.
// SPI words cannot be stalled, so they land in a small FIFO first. SPI has priority in IDLE.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   spi_rx_data/spi_rx_valid   10-bit command words from the SPI slave ([9:8] = cmd)
//   spi_tx_data/spi_tx_valid   8-bit read data back to the SPI slave
//   host_req/host_cmd          host request, command held stable until granted
//   host_gnt                   combinational grant: host_cmd is taken this cycle
//   host_rdata/host_rvalid     8-bit read data to the host
//   ram_din/ram_rx_valid       command word and issue strobe to the RAM
//   ram_dout/ram_tx_valid      read data and strobe from the RAM
//   spi_ovf                    pulse: SPI word dropped, FIFO full
//   lock_err                   pulse: idle lock released by timeout
//   rd_err                     pulse: read abandoned by timeout
//   busy                       state is not IDLE
module spi_ram_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int LOCK_TIMEOUT = 64,
  parameter int RD_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] spi_rx_data,
  input  logic       spi_rx_valid,
  output logic [7:0] spi_tx_data,
  output logic       spi_tx_valid,
  input  logic       host_req,
  input  logic [9:0] host_cmd,
  output logic       host_gnt,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       spi_ovf,
  output logic       lock_err,
  output logic       rd_err,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(RD_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RD_LAST   = RW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOCK_SPI, LOCK_HOST, RD_SPI, RD_HOST} state_t;

  state_t        state, state_n;
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic [9:0]    fifo_head;
  logic [LW-1:0] lock_tmr, lock_tmr_n;
  logic [RW-1:0] rd_tmr, rd_tmr_n;
  logic          acc_valid, acc_spi;
  logic [9:0]    acc_word;
  logic          lock_err_n, rd_err_n, spi_rd_done, host_rd_done;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = spi_rx_valid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= spi_rx_data;
  end

  always_comb begin
    state_n      = state;
    acc_valid    = 1'b0;
    acc_spi      = 1'b0;
    acc_word     = 10'h000;
    host_gnt     = 1'b0;
    pop          = 1'b0;
    lock_tmr_n   = lock_tmr;
    rd_tmr_n     = rd_tmr;
    lock_err_n   = 1'b0;
    rd_err_n     = 1'b0;
    spi_rd_done  = 1'b0;
    host_rd_done = 1'b0;

    case (state)
      IDLE: begin
        // A word arriving on the SPI side this very cycle also beats the host,
        // so simultaneous requests resolve to SPI even though the FIFO adds a cycle.
        if (!fifo_empty) begin
          acc_valid = 1'b1;
          acc_spi   = 1'b1;
        end else if (host_req && !spi_rx_valid) begin
          acc_valid = 1'b1;
          host_gnt  = 1'b1;
        end
      end
      LOCK_SPI: begin
        if (!fifo_empty) begin
          acc_valid = 1'b1;
          acc_spi   = 1'b1;
        end
      end
      LOCK_HOST: begin
        if (host_req) begin
          acc_valid = 1'b1;
          host_gnt  = 1'b1;
        end
      end
      RD_SPI, RD_HOST: begin
        if (ram_tx_valid) begin
          state_n      = IDLE;
          rd_tmr_n     = '0;
          spi_rd_done  = (state == RD_SPI);
          host_rd_done = (state == RD_HOST);
        end else if (rd_tmr == RD_LAST) begin
          state_n  = IDLE;
          rd_tmr_n = '0;
          rd_err_n = 1'b1;
        end else begin
          rd_tmr_n = rd_tmr + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (acc_valid) begin
      acc_word   = acc_spi ? fifo_head : host_cmd;
      pop        = acc_spi;
      lock_tmr_n = '0;
      case (acc_word[9:8])
        2'b01:   state_n = IDLE;
        2'b11: begin
          state_n  = acc_spi ? RD_SPI : RD_HOST;
          rd_tmr_n = '0;
        end
        default: state_n = acc_spi ? LOCK_SPI : LOCK_HOST;
      endcase
    end else if (state == LOCK_SPI || state == LOCK_HOST) begin
      if (lock_tmr == LOCK_LAST) begin
        state_n    = IDLE;
        lock_tmr_n = '0;
        lock_err_n = 1'b1;
      end else begin
        lock_tmr_n = lock_tmr + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lock_tmr     <= '0;
      rd_tmr       <= '0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
      spi_tx_data  <= 8'h00;
      spi_tx_valid <= 1'b0;
      host_rdata   <= 8'h00;
      host_rvalid  <= 1'b0;
      spi_ovf      <= 1'b0;
      lock_err     <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      state        <= state_n;
      lock_tmr     <= lock_tmr_n;
      rd_tmr       <= rd_tmr_n;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      ram_rx_valid <= acc_valid;
      if (acc_valid) ram_din <= acc_word;
      spi_tx_valid <= spi_rd_done;
      if (spi_rd_done) spi_tx_data <= ram_dout;
      host_rvalid  <= host_rd_done;
      if (host_rd_done) host_rdata <= ram_dout;
      spi_ovf      <= spi_rx_valid && fifo_full;
      lock_err     <= lock_err_n;
      rd_err       <= rd_err_n;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - directed self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic [9:0] host_cmd;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       spi_ovf;
  logic       lock_err;
  logic       rd_err;
  logic       busy;

  spi_ram_arbiter #(.FIFO_DEPTH(2), .LOCK_TIMEOUT(64), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .host_req(host_req), .host_cmd(host_cmd), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .spi_ovf(spi_ovf), .lock_err(lock_err), .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] issued [$];
  int ovf_cnt = 0, lock_cnt = 0, rderr_cnt = 0, spi_tv_cnt = 0, host_rv_cnt = 0;

  always @(negedge clk) begin
    if (ram_rx_valid) issued.push_back(ram_din);
    if (spi_ovf)      ovf_cnt++;
    if (lock_err)     lock_cnt++;
    if (rd_err)       rderr_cnt++;
    if (spi_tx_valid) spi_tv_cnt++;
    if (host_rvalid)  host_rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] iss(input int i);
    if (i < issued.size()) return 32'(issued[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ram_din"}, ram_din, 0);
    check({pfx, "_ram_rx_valid"}, ram_rx_valid, 0);
    check({pfx, "_spi_tx_data"}, spi_tx_data, 0);
    check({pfx, "_spi_tx_valid"}, spi_tx_valid, 0);
    check({pfx, "_host_rdata"}, host_rdata, 0);
    check({pfx, "_host_rvalid"}, host_rvalid, 0);
    check({pfx, "_host_gnt"}, host_gnt, 0);
    check({pfx, "_errs"}, {spi_ovf, lock_err, rd_err}, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b, c, d, n;
    rst_n = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
    host_req = 1'b0; host_cmd = '0; ram_dout = '0; ram_tx_valid = 1'b0;
    tick; tick;
    check_all_zero("rst");
    rst_n = 1'b1;
    tick; tick;

    // SPI write: 0x012 then 0x1A5, host locked out meanwhile
    b = issued.size();
    spi_rx_data = 10'h012; spi_rx_valid = 1'b1; tick; spi_rx_valid = 1'b0;
    tick;
    check("t1_busy_lock", busy, 1);
    host_req = 1'b1; host_cmd = 10'h155; #1;
    check("t1_gnt_locked0", host_gnt, 0);
    spi_rx_data = 10'h1A5; spi_rx_valid = 1'b1; tick; spi_rx_valid = 1'b0;
    check("t1_gnt_locked1", host_gnt, 0);
    tick;
    check("t1_idle", busy, 0);
    host_req = 1'b0;
    tick; tick;
    check("t1_iss0", iss(b), 10'h012);
    check("t1_iss1", iss(b+1), 10'h1A5);
    check("t1_iss_n", issued.size() - b, 2);

    // Host read: 0x212, 0x300, RAM returns 0xA5
    b = issued.size(); c = spi_tv_cnt;
    host_req = 1'b1; host_cmd = 10'h212; #1;
    check("t2_gnt_addr", host_gnt, 1);
    tick; host_cmd = 10'h300; #1;
    check("t2_gnt_data", host_gnt, 1);
    tick; host_req = 1'b0;
    check("t2_rd_busy", busy, 1);
    tick; ram_dout = 8'hA5; ram_tx_valid = 1'b1;
    tick; ram_tx_valid = 1'b0; ram_dout = 8'h00;
    check("t2_rvalid", host_rvalid, 1);
    check("t2_rdata", host_rdata, 8'hA5);
    check("t2_spi_tv", spi_tx_valid, 0);
    check("t2_idle", busy, 0);
    tick;
    check("t2_rvalid_pulse", host_rvalid, 0);
    tick;
    check("t2_iss0", iss(b), 10'h212);
    check("t2_iss1", iss(b+1), 10'h300);
    check("t2_no_spi_data", spi_tv_cnt - c, 0);

    // Contention: SPI wins, then SPI words buffered during LOCK_HOST
    b = issued.size();
    host_req = 1'b1; host_cmd = 10'h077;
    spi_rx_data = 10'h0AA; spi_rx_valid = 1'b1; #1;
    check("t3_gnt_simul", host_gnt, 0);
    tick; spi_rx_valid = 1'b0; #1;
    check("t3_gnt_fifo", host_gnt, 0);
    tick;
    spi_rx_data = 10'h1BB; spi_rx_valid = 1'b1; tick; spi_rx_valid = 1'b0;
    tick;
    check("t3_gnt_after", host_gnt, 1);
    tick; host_req = 1'b0;
    spi_rx_data = 10'h0CC; spi_rx_valid = 1'b1; tick;
    spi_rx_data = 10'h1DD; tick; spi_rx_valid = 1'b0;
    check("t3_hold_busy", busy, 1);
    tick; tick;
    check("t3_buffered", issued.size() - b, 3);
    host_req = 1'b1; host_cmd = 10'h188; #1;
    check("t3_gnt_owner", host_gnt, 1);
    tick; host_req = 1'b0;
    tick; tick; tick; tick;
    check("t3_iss0", iss(b),   10'h0AA);
    check("t3_iss1", iss(b+1), 10'h1BB);
    check("t3_iss2", iss(b+2), 10'h077);
    check("t3_iss3", iss(b+3), 10'h188);
    check("t3_iss4", iss(b+4), 10'h0CC);
    check("t3_iss5", iss(b+5), 10'h1DD);

    // Overflow: 3 SPI words while host holds the lock
    b = issued.size(); c = ovf_cnt;
    host_req = 1'b1; host_cmd = 10'h011; tick; host_req = 1'b0;
    spi_rx_valid = 1'b1;
    spi_rx_data = 10'h033; tick;
    spi_rx_data = 10'h144; tick;
    spi_rx_data = 10'h155; tick;
    spi_rx_valid = 1'b0;
    tick;
    check("t4_ovf_one", ovf_cnt - c, 1);
    host_req = 1'b1; host_cmd = 10'h166; tick; host_req = 1'b0;
    tick; tick; tick; tick;
    check("t4_iss0", iss(b),   10'h011);
    check("t4_iss1", iss(b+1), 10'h166);
    check("t4_iss2", iss(b+2), 10'h033);
    check("t4_iss3", iss(b+3), 10'h144);
    check("t4_iss_n", issued.size() - b, 4);

    // Lock timeout after host wr-addr 0x005
    c = lock_cnt;
    host_req = 1'b1; host_cmd = 10'h005; tick; host_req = 1'b0;
    n = 0;
    while (!lock_err && n < 200) begin tick; n++; end
    check("t5_lock_cycles", n, 64);
    check("t5_lock_idle", busy, 0);
    tick;
    check("t5_lock_pulse", lock_err, 0);
    check("t5_lock_cnt", lock_cnt - c, 1);

    // Read timeout, then a late ram_tx_valid in IDLE
    c = rderr_cnt; d = host_rv_cnt; b = spi_tv_cnt;
    host_req = 1'b1; host_cmd = 10'h300; tick; host_req = 1'b0;
    n = 0;
    while (!rd_err && n < 100) begin tick; n++; end
    check("t5_rd_cycles", n, 16);
    check("t5_rd_idle", busy, 0);
    ram_dout = 8'h5A; ram_tx_valid = 1'b1; tick; ram_tx_valid = 1'b0; ram_dout = 8'h00;
    tick; tick;
    check("t5_rd_no_hdata", host_rv_cnt - d, 0);
    check("t5_rd_no_sdata", spi_tv_cnt - b, 0);
    check("t5_rd_rdata_kept", host_rdata, 8'hA5);
    check("t5_rd_cnt", rderr_cnt - c, 1);

    // Reset in RD_SPI with one word pending in the FIFO
    spi_rx_data = 10'h300; spi_rx_valid = 1'b1; tick;
    spi_rx_data = 10'h077; tick; spi_rx_valid = 1'b0;
    check("t6_rd_spi_busy", busy, 1);
    rst_n = 1'b0; #1;
    check_all_zero("t6");
    tick; tick;
    rst_n = 1'b1;
    b = issued.size(); c = spi_tv_cnt;
    ram_dout = 8'hFF; ram_tx_valid = 1'b1; tick; ram_tx_valid = 1'b0; ram_dout = 8'h00;
    tick; tick; tick;
    check("t6_no_issue", issued.size() - b, 0);
    check("t6_no_spi_data", spi_tv_cnt - c, 0);
    check("t6_idle", busy, 0);
    host_req = 1'b1; host_cmd = 10'h1EE; #1;
    check("t6_fifo_empty_gnt", host_gnt, 1);
    host_req = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Shares the single-port command RAM (`SYN_RAM`, 10-bit command words, 8-bit read data) between the SPI slave (`FSM_SPI`) and a local host requester. It sits between both requesters and the RAM, replacing the direct rx/tx connection in the top level. The RAM latches addresses internally, so the arbiter locks the RAM to one owner for a whole transaction: an address command followed by its data command, plus read return. SPI words cannot be stalled, so they are buffered in a small FIFO, and SPI wins arbitration in IDLE.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: SPI word buffer depth (power of 2, ≥2).
- `LOCK_TIMEOUT`, 64: cycles a locked owner may stay idle before forced release.
- `RD_TIMEOUT`, 16: cycles to wait for `ram_tx_valid` after a read-data command.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_rx_data`  in  10  command word from SPI slave; [9:8] = cmd (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- `spi_rx_valid`  in  1  one-cycle strobe for `spi_rx_data`.
- `spi_tx_data`  out  8  read data back to the SPI slave.
- `spi_tx_valid`  out  1  one-cycle strobe for `spi_tx_data`.
- `host_req`  in  1  host holds this high with a stable `host_cmd` until granted.
- `host_cmd`  in  10  host command word, same encoding.
- `host_gnt`  out  1  combinational; high in the cycle `host_cmd` is accepted.
- `host_rdata`  out  8  read data to host.
- `host_rvalid`  out  1  one-cycle strobe for `host_rdata`.
- `ram_din`  out  10  command word to RAM.
- `ram_rx_valid`  out  1  one-cycle issue strobe to RAM.
- `ram_dout`  in  8  RAM read data.
- `ram_tx_valid`  in  1  RAM read-data strobe.
- `spi_ovf`  out  1  one-cycle pulse: SPI word dropped because the FIFO was full.
- `lock_err`  out  1  one-cycle pulse: lock released by `LOCK_TIMEOUT`.
- `rd_err`  out  1  one-cycle pulse: read abandoned by `RD_TIMEOUT`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- The SPI FIFO pushes on `spi_rx_valid`. Push and pop in the same cycle are legal. A push while full drops the word and pulses `spi_ovf`; FIFO contents are unchanged.
- States: IDLE, LOCK_SPI, LOCK_HOST, RD_SPI, RD_HOST.
- **Acceptance** means one word per cycle at most. The word is copied to `ram_din` and `ram_rx_valid` is pulsed on the next cycle.
- **IDLE:**
  - If the FIFO is not empty, accept the FIFO head (pop). Otherwise, if `host_req` is high, accept `host_cmd` (`host_gnt`=1). SPI wins on simultaneous requests.
  - Next state by cmd of the accepted word: 00/10 → LOCK_owner; 01 → IDLE; 11 → RD_owner.
- **LOCK_X:**
  - Only owner X is accepted. The non-owner waits: host gets `host_gnt`=0; SPI words stay in the FIFO.
  - Transitions on an accepted word: cmd 00/10 → stay and restart the lock timer; 01 → IDLE; 11 → RD_X.
  - If there is no acceptance for `LOCK_TIMEOUT` consecutive cycles: → IDLE and pulse `lock_err`.
- **RD_X:**
  - No acceptance. On `ram_tx_valid`, route `ram_dout` to X's data/valid outputs on the next cycle, then → IDLE.
  - If the wait reaches `RD_TIMEOUT` cycles: → IDLE, pulse `rd_err`, and return no data. A late `ram_tx_valid` outside RD_X is ignored.
- `ram_tx_valid` is ignored in all states other than RD_X.
- Reset values: state IDLE, FIFO empty, timers 0. All outputs are 0: `ram_din`, `spi_tx_data`, and `host_rdata` are 0; all strobes, errors, and `busy` are 0.
- A reset mid-transaction discards buffered words and any lock. No strobe is emitted after reset is released until a new acceptance occurs.

## Timing
- Acceptance at edge k → `ram_rx_valid`=1 during cycle k..k+1.
- RAM read latency is 1 cycle: `ram_tx_valid` arrives one cycle after `ram_rx_valid`, and `spi_tx_valid`/`host_rvalid` rise one cycle after that.
- The SPI word path adds one FIFO cycle: `spi_rx_valid` at edge k gives the earliest acceptance at edge k+1 and `ram_rx_valid` in cycle k+2.
- The arbiter can issue back-to-back (one per cycle) from IDLE or LOCK.
- The lock timer counts cycles in LOCK_X since entry or last acceptance. Release happens on the cycle the count equals `LOCK_TIMEOUT`.
- The read timer counts from RD entry. Release happens when the count equals `RD_TIMEOUT`.

## Test plan
- **SPI write:** SPI sends 0x0_12 (wr-addr 0x12) then 0x1_A5. Require RAM issues 0x012 then 0x1A5, state goes LOCK_SPI→IDLE, and `host_gnt` stays 0 while locked even with `host_req`=1.
- **Host read:** host sends 0x2_12 then 0x3_00 with RAM returning 0xA5. Require `host_rvalid`=1 with `host_rdata`=0xA5 one cycle after `ram_tx_valid`, and `spi_tx_valid` stays 0.
- **Contention:** `host_req` and `spi_rx_valid` both rise in IDLE. Require SPI to win, host granted only after the SPI transaction reaches IDLE. SPI words arriving during LOCK_HOST are buffered and issued in order after release.
- **Overflow:** hold LOCK_HOST and push 3 SPI words with `FIFO_DEPTH`=2. Require exactly one `spi_ovf` pulse on the 3rd word, and the first two are issued later unchanged.
- **Timeouts:** host sends 0x0_05 then stays silent. Require `lock_err` at cycle 64 and return to IDLE. A read with no `ram_tx_valid` → `rd_err` at cycle 16 with no data strobe.
- **Reset mid-read:** drive `rst_n`=0 in RD_SPI with 1 FIFO entry pending. Require all outputs 0, FIFO empty, and no strobes after release.
